// File: rtl/vga_tile_renderer_if.sv
// Tile map write port bundle: request (wr_en/wr_addr/wr_data) from the CPU
// side, one-cycle wr_ack / wr_err responses from the renderer.
interface vga_tile_renderer_if;
    logic       wr_en;
    logic [8:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_ack;
    logic       wr_err;

    modport master (
        output wr_en, wr_addr, wr_data,
        input  wr_ack, wr_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        output wr_ack, wr_err
    );
endinterface

// File: rtl/vga_tile_renderer.sv
// Tile-map VGA renderer: 3-stage pixel pipeline (index, map read, colour)
// advanced by pix_en, with a post-reset clear engine and a CPU write port.
// Ports: clk/reset, pix_en, tile coords + sub offsets, active/sync inputs,
// wr (write port interface), busy, RGB332 colour, delayed hsync/vsync.
module vga_tile_renderer #(
    parameter int MAP_W = 20,
    parameter int MAP_H = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic [4:0] xSupPix,
    input  logic [3:0] ySupPix,
    input  logic [4:0] xSubCount,
    input  logic [4:0] ySubCount,
    input  logic       active_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
    vga_tile_renderer_if.slave wr,
    output logic       busy,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue,
    output logic       hsync,
    output logic       vsync
);
    localparam int DEPTH = MAP_W * MAP_H;
    localparam logic [8:0] LAST = 9'(DEPTH - 1);
    localparam logic [8:0] DEPTH9 = 9'(DEPTH);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t     state;
    logic [8:0] clr_addr;

    logic [3:0] map [DEPTH];
    logic       mem_we;
    logic [8:0] mem_waddr;
    logic [3:0] mem_wdata;
    logic       addr_ok;

    assign addr_ok = wr.wr_addr < DEPTH9;

    // Control FSM: clear sweep, then RUN with write responses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= CLEAR;
            clr_addr  <= '0;
            busy      <= 1'b1;
            wr.wr_ack <= 1'b0;
            wr.wr_err <= 1'b0;
        end else begin
            wr.wr_ack <= 1'b0;
            wr.wr_err <= 1'b0;
            case (state)
                CLEAR: begin
                    wr.wr_err <= wr.wr_en;
                    if (clr_addr == LAST) begin
                        state    <= RUN;
                        busy     <= 1'b0;
                        clr_addr <= '0;
                    end else begin
                        clr_addr <= clr_addr + 9'd1;
                    end
                end
                RUN: begin
                    if (wr.wr_en) begin
                        wr.wr_ack <= addr_ok;
                        wr.wr_err <= !addr_ok;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Single write port shared by the clear engine and the CPU.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_addr;
        mem_wdata = 4'd0;
        if (state == CLEAR) begin
            mem_we = 1'b1;
        end else if (wr.wr_en && addr_ok) begin
            mem_we    = 1'b1;
            mem_waddr = wr.wr_addr;
            mem_wdata = wr.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            map[mem_waddr] <= mem_wdata;
    end

    // Stage 1: tile index and sideband.
    logic [8:0] s1_idx;
    logic [4:0] s1_sx, s1_sy;
    logic       s1_hs, s1_vs, s1_vis;
    // Stage 2: tile id and sideband.
    logic [3:0] s2_tile;
    logic [4:0] s2_sx, s2_sy;
    logic       s2_hs, s2_vs, s2_vis;

    logic [8:0] idx;
    logic       vis;

    // y*20 + x as shift-and-add
    assign idx = {1'b0, ySupPix, 4'b0000}
               + {3'b000, ySupPix, 2'b00}
               + {4'b0000, xSupPix};
    assign vis = active_in
               && (xSupPix < 5'(MAP_W))
               && (ySupPix < 4'(MAP_H));

    logic [7:0] fg;
    logic       fg_bit;
    logic [7:0] rgb_next;

    always_comb begin
        fg = 8'hFF;
        case (s2_tile[1:0])
            2'd0: fg = 8'hFF;
            2'd1: fg = 8'hE0;
            2'd2: fg = 8'h1C;
            2'd3: fg = 8'h03;
            default: fg = 8'hFF;
        endcase
        fg_bit = 1'b1;
        case (s2_tile[3:2])
            2'd0: fg_bit = 1'b1;
            2'd1: fg_bit = (s2_sx == 5'd0) || (s2_sx == 5'd31)
                        || (s2_sy == 5'd0) || (s2_sy == 5'd31);
            2'd2: fg_bit = s2_sx[2] ^ s2_sy[2];
            2'd3: fg_bit = (s2_sx == s2_sy);
            default: fg_bit = 1'b1;
        endcase
        rgb_next = 8'h00;
        if (s2_vis && (s2_tile != 4'd0) && (state == RUN) && fg_bit)
            rgb_next = fg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_idx  <= '0;
            s1_sx   <= '0;
            s1_sy   <= '0;
            s1_hs   <= 1'b1;
            s1_vs   <= 1'b1;
            s1_vis  <= 1'b0;
            s2_tile <= '0;
            s2_sx   <= '0;
            s2_sy   <= '0;
            s2_hs   <= 1'b1;
            s2_vs   <= 1'b1;
            s2_vis  <= 1'b0;
            red     <= '0;
            green   <= '0;
            blue    <= '0;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
        end else if (pix_en) begin
            s1_idx  <= idx;
            s1_sx   <= xSubCount;
            s1_sy   <= ySubCount;
            s1_hs   <= hsync_in;
            s1_vs   <= vsync_in;
            s1_vis  <= vis;
            // Read sees the pre-write value on a same-cycle collision.
            s2_tile <= (s1_idx < DEPTH9) ? map[s1_idx] : 4'd0;
            s2_sx   <= s1_sx;
            s2_sy   <= s1_sy;
            s2_hs   <= s1_hs;
            s2_vs   <= s1_vs;
            s2_vis  <= s1_vis;
            red     <= rgb_next[7:5];
            green   <= rgb_next[4:2];
            blue    <= rgb_next[1:0];
            hsync   <= s2_hs;
            vsync   <= s2_vs;
        end
    end
endmodule

// File: tb/tb_vga_tile_renderer.sv
// Self-checking bench for vga_tile_renderer against a spec-level model
// of the tile map and pixel rule.
module tb_vga_tile_renderer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_en = 1'b0;
    logic [4:0] xSupPix = '0;
    logic [3:0] ySupPix = '0;
    logic [4:0] xSubCount = '0;
    logic [4:0] ySubCount = '0;
    logic       active_in = 1'b0;
    logic       hsync_in = 1'b1;
    logic       vsync_in = 1'b1;
    logic       busy;
    logic [2:0] red, green;
    logic [1:0] blue;
    logic       hsync, vsync;

    vga_tile_renderer_if bus();

    vga_tile_renderer dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .xSupPix(xSupPix), .ySupPix(ySupPix),
        .xSubCount(xSubCount), .ySubCount(ySubCount),
        .active_in(active_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .wr(bus), .busy(busy),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ref_map [300];

    typedef struct {
        logic [7:0] rgb;
        logic       hs;
        logic       vs;
    } exp_t;

    function automatic logic [7:0] ref_rgb(int x, int y, int sx, int sy, bit act);
        int t;
        bit on;
        logic [7:0] fg;
        if (!act || x >= 20 || y >= 15) return 8'h00;
        t = ref_map[y * 20 + x];
        if (t == 0) return 8'h00;
        case (t % 4)
            0: fg = 8'hFF;
            1: fg = 8'hE0;
            2: fg = 8'h1C;
            default: fg = 8'h03;
        endcase
        case (t / 4)
            0: on = 1;
            1: on = (sx == 0 || sx == 31 || sy == 0 || sy == 31);
            2: on = ((sx / 4) % 2) != ((sy / 4) % 2);
            default: on = (sx == sy);
        endcase
        return on ? fg : 8'h00;
    endfunction

    function automatic logic [7:0] rgb_out();
        return {red, green, blue};
    endfunction

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One pixel strobe followed by one quiet cycle.
    task automatic strobe(input int x, input int y, input int sx, input int sy,
                          input bit act, input bit hs, input bit vs);
        xSupPix = 5'(x);
        ySupPix = 4'(y);
        xSubCount = 5'(sx);
        ySubCount = 5'(sy);
        active_in = act;
        hsync_in = hs;
        vsync_in = vs;
        pix_en = 1'b1;
        @(posedge clk);
        #1;
        pix_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pixel(input int x, input int y, input int sx, input int sy,
                         input bit act, input bit hs, output logic [7:0] rgb,
                         output logic h);
        strobe(x, y, sx, sy, act, hs, 1'b1);
        strobe(0, 0, 0, 0, 1'b0, 1'b1, 1'b1);
        strobe(0, 0, 0, 0, 1'b0, 1'b1, 1'b1);
        rgb = rgb_out();
        h = hsync;
    endtask

    task automatic write(input int a, input int d, output bit ack, output bit err);
        bus.wr_en = 1'b1;
        bus.wr_addr = 9'(a);
        bus.wr_data = 4'(d);
        @(posedge clk);
        #1;
        ack = bus.wr_ack;
        err = bus.wr_err;
        bus.wr_en = 1'b0;
        if (a < 300) ref_map[a] = d;
    endtask

    // Counts busy-high cycles after reset release; bounded loop.
    task automatic count_clear(output int cnt);
        cnt = 0;
        for (int c = 0; c < 320; c++) begin
            if (busy) cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int cnt;
        logic [7:0] rgb;
        logic h;
        foreach (ref_map[i]) ref_map[i] = 0;
        reset = 1'b1;
        idle(2);
        checks++;
        if (rgb_out() !== 8'h00 || hsync !== 1'b1 || vsync !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: rgb=%h hs=%b vs=%b want 00 1 1",
                     rgb_out(), hsync, vsync);
        end
        checks++;
        if (busy !== 1'b1 || bus.wr_ack !== 1'b0 || bus.wr_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b ack=%b err=%b want 1 0 0",
                     busy, bus.wr_ack, bus.wr_err);
        end
        reset = 1'b0;
        cnt = 0;
        for (int c = 0; c < 320; c++) begin
            if (busy) cnt++;
            if (c == 10) begin
                bus.wr_en = 1'b1;
                bus.wr_addr = 9'd5;
                bus.wr_data = 4'hD;
            end
            @(posedge clk);
            #1;
            if (c == 10) begin
                bus.wr_en = 1'b0;
                checks++;
                if (bus.wr_err !== 1'b1 || bus.wr_ack !== 1'b0) begin
                    errors++;
                    $display("FAIL clear_write_rejected: err=%b ack=%b want 1 0",
                             bus.wr_err, bus.wr_ack);
                end
            end
        end
        checks++;
        if (cnt !== 300 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_length: busy cycles=%0d busy=%b want 300 0", cnt, busy);
        end
        pixel(5, 0, 0, 3, 1'b1, 1'b1, rgb, h);
        checks++;
        if (rgb !== ref_rgb(5, 0, 0, 3, 1'b1)) begin
            errors++;
            $display("FAIL clear_entry_kept: rgb=%h want %h", rgb, ref_rgb(5, 0, 0, 3, 1'b1));
        end
    endtask

    task automatic test_border();
        bit ack, err;
        logic [7:0] rgb;
        logic h;
        write(21, 5, ack, err);
        checks++;
        if (ack !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL border_write_ack: ack=%b err=%b want 1 0", ack, err);
        end
        pixel(1, 1, 0, 7, 1'b1, 1'b1, rgb, h);
        checks++;
        if (rgb !== 8'hE0) begin
            errors++;
            $display("FAIL border_edge: rgb=%h want e0", rgb);
        end
        pixel(1, 1, 5, 7, 1'b1, 1'b1, rgb, h);
        checks++;
        if (rgb !== 8'h00) begin
            errors++;
            $display("FAIL border_inner: rgb=%h want 00", rgb);
        end
    endtask

    task automatic test_checker();
        bit ack, err;
        logic [7:0] rgb;
        logic h;
        write(0, 8, ack, err);
        pixel(0, 0, 4, 0, 1'b1, 1'b1, rgb, h);
        checks++;
        if (rgb !== 8'hFF) begin
            errors++;
            $display("FAIL checker_on: rgb=%h want ff", rgb);
        end
        pixel(0, 0, 4, 4, 1'b1, 1'b1, rgb, h);
        checks++;
        if (rgb !== 8'h00) begin
            errors++;
            $display("FAIL checker_off: rgb=%h want 00", rgb);
        end
    endtask

    task automatic test_sync();
        bit ack, err;
        logic [7:0] rgb;
        logic h;
        strobe(1, 1, 0, 7, 1'b1, 1'b0, 1'b1);
        strobe(0, 0, 0, 0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (hsync !== 1'b1) begin
            errors++;
            $display("FAIL hsync_early: hsync=%b want 1", hsync);
        end
        strobe(0, 0, 0, 0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (hsync !== 1'b0 || rgb_out() !== 8'hE0) begin
            errors++;
            $display("FAIL hsync_aligned: hsync=%b rgb=%h want 0 e0", hsync, rgb_out());
        end
        strobe(0, 0, 0, 0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (hsync !== 1'b1 || rgb_out() !== 8'h00) begin
            errors++;
            $display("FAIL hsync_release: hsync=%b rgb=%h want 1 00", hsync, rgb_out());
        end
        write(42, 15, ack, err);
        pixel(2, 2, 9, 9, 1'b0, 1'b1, rgb, h);
        checks++;
        if (rgb !== 8'h00) begin
            errors++;
            $display("FAIL inactive_blank: rgb=%h want 00", rgb);
        end
    endtask

    task automatic test_bad_addr();
        bit ack, err;
        logic [7:0] rgb;
        logic h;
        write(300, 7, ack, err);
        checks++;
        if (err !== 1'b1 || ack !== 1'b0) begin
            errors++;
            $display("FAIL bad_addr_err: err=%b ack=%b want 1 0", err, ack);
        end
        pixel(0, 0, 0, 0, 1'b1, 1'b1, rgb, h);
        checks++;
        if (rgb !== ref_rgb(0, 0, 0, 0, 1'b1)) begin
            errors++;
            $display("FAIL bad_addr_alias0: rgb=%h want %h", rgb, ref_rgb(0, 0, 0, 0, 1'b1));
        end
        write(299, 3, ack, err);
        // Read of 299 on the same edge as a write of a new id.
        strobe(19, 14, 0, 0, 1'b1, 1'b1, 1'b1);
        bus.wr_en = 1'b1;
        bus.wr_addr = 9'd299;
        bus.wr_data = 4'd2;
        pix_en = 1'b1;
        xSupPix = '0;
        ySupPix = '0;
        active_in = 1'b0;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        pix_en = 1'b0;
        checks++;
        if (bus.wr_ack !== 1'b1 || bus.wr_err !== 1'b0) begin
            errors++;
            $display("FAIL collide_ack: ack=%b err=%b want 1 0", bus.wr_ack, bus.wr_err);
        end
        idle(1);
        strobe(0, 0, 0, 0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (rgb_out() !== 8'h03) begin
            errors++;
            $display("FAIL collide_old: rgb=%h want 03", rgb_out());
        end
        ref_map[299] = 2;
        pixel(19, 14, 0, 0, 1'b1, 1'b1, rgb, h);
        checks++;
        if (rgb !== 8'h1C) begin
            errors++;
            $display("FAIL collide_new: rgb=%h want 1c", rgb);
        end
    endtask

    task automatic test_hold();
        logic [7:0] rgb;
        logic h;
        pixel(1, 1, 31, 3, 1'b1, 1'b0, rgb, h);
        for (int i = 0; i < 20; i++) begin
            xSupPix = 5'($urandom_range(0, 19));
            xSubCount = 5'($urandom_range(0, 31));
            hsync_in = 1'b1;
            active_in = 1'b1;
            idle(1);
        end
        checks++;
        if (rgb_out() !== 8'hE0 || hsync !== 1'b0) begin
            errors++;
            $display("FAIL pix_en_hold: rgb=%h hsync=%b want e0 0", rgb_out(), hsync);
        end
    endtask

    task automatic test_random();
        bit ack, err;
        exp_t q[$];
        exp_t e, f;
        int a, x, y, sx, sy;
        bit act, hs, vs;
        for (int i = 0; i < 40; i++) begin
            a = ($urandom % 8 == 0) ? $urandom_range(300, 511) : $urandom_range(0, 299);
            write(a, $urandom_range(0, 15), ack, err);
            checks++;
            if (ack !== (a < 300) || err !== (a >= 300)) begin
                errors++;
                $display("FAIL rand_write_resp: addr=%0d ack=%b err=%b", a, ack, err);
            end
        end
        for (int i = 0; i < 80; i++) begin
            x = $urandom_range(0, 21);
            y = $urandom_range(0, 15);
            sx = $urandom_range(0, 31);
            sy = ($urandom % 4 == 0) ? sx : $urandom_range(0, 31);
            act = ($urandom % 4) != 0;
            hs = $urandom % 2;
            vs = $urandom % 2;
            e.rgb = ref_rgb(x, y, sx, sy, act);
            e.hs = hs;
            e.vs = vs;
            strobe(x, y, sx, sy, act, hs, vs);
            q.push_back(e);
            if (q.size() == 3) begin
                f = q.pop_front();
                checks++;
                if (rgb_out() !== f.rgb || hsync !== f.hs || vsync !== f.vs) begin
                    errors++;
                    $display("FAIL rand_pixel: rgb=%h hs=%b vs=%b want %h %b %b",
                             rgb_out(), hsync, vsync, f.rgb, f.hs, f.vs);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ack, err;
        int cnt;
        logic [7:0] rgb;
        logic h;
        write(0, 1, ack, err);
        pixel(0, 0, 9, 9, 1'b1, 1'b0, rgb, h);
        checks++;
        if (rgb !== 8'hE0 || h !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_pixel: rgb=%h hsync=%b want e0 0", rgb, h);
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (rgb_out() !== 8'h00 || hsync !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: rgb=%h hsync=%b busy=%b want 00 1 1",
                     rgb_out(), hsync, busy);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        foreach (ref_map[i]) ref_map[i] = 0;
        count_clear(cnt);
        checks++;
        if (cnt !== 300 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reclear_length: busy cycles=%0d busy=%b want 300 0", cnt, busy);
        end
        for (int i = 0; i < 6; i++) begin
            int x, y;
            x = (i == 0) ? 0 : $urandom_range(0, 19);
            y = (i == 0) ? 0 : $urandom_range(0, 14);
            pixel(x, y, 0, 0, 1'b1, 1'b1, rgb, h);
            checks++;
            if (rgb !== 8'h00) begin
                errors++;
                $display("FAIL cleared_tile: x=%0d y=%0d rgb=%h want 00", x, y, rgb);
            end
        end
    endtask

    initial begin
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        test_reset();
        test_border();
        test_checker();
        test_sync();
        test_bad_addr();
        test_hold();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
